// File: rtl/flappy_pkg.sv
// flappy_pkg: shared defaults, types and pipe arithmetic for the pipe scheduler.
// Coordinates are 12-bit unsigned pixels. The gap-centre value y is the pipe's
// vertical position; x is the pipe's right edge.
package flappy_pkg;

    localparam int unsigned DEF_SCREEN_W     = 1024;
    localparam int unsigned DEF_PIPE_W       = 64;
    localparam int unsigned DEF_PIPE_SPACING = 352;
    localparam int unsigned DEF_SPEED        = 4;
    localparam int unsigned DEF_GAP_MIN      = 192;
    localparam int unsigned DEF_GAP_Y_INIT   = 384;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam int unsigned COORD_W   = 12;
    localparam int unsigned NUM_PIPES = 3;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_STEP0 = 3'd2,
        ST_STEP1 = 3'd3,
        ST_STEP2 = 3'd4
    } sched_state_e;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } pipe_t;

    // Move a pipe left by spd. A pipe at or left of spd wraps to the back of
    // the queue; the add is done as x + (wrap - spd) so no intermediate value
    // ever goes below zero.
    function automatic pipe_t advance_pipe(input pipe_t  p,
                                           input coord_t spd,
                                           input coord_t wrap,
                                           input coord_t fresh_y);
        pipe_t r;
        if (p.x <= spd) begin
            r.x = p.x + (wrap - spd);
            r.y = fresh_y;
        end else begin
            r.x = p.x - spd;
            r.y = p.y;
        end
        return r;
    endfunction

    // True when the pipe's right edge crosses the bird column during this move.
    function automatic logic crosses_bird(input coord_t x_old,
                                          input coord_t x_new,
                                          input coord_t bird);
        return (x_old > bird) && (x_new <= bird);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Seeded with LFSR_SEED on reset only; steps every clock.
module lfsr16
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic        fb;

    // Next state: shift right, feedback from the tap bits into the MSB
    always_comb begin
        fb  = q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5];
        q_d = {fb, q_q[15:1]};
        // Lock-up guard: a maximal-length sequence never yields zero, but a
        // corrupted state must not stick there forever.
        if (q_d == 16'h0000) begin
            q_d = LFSR_SEED;
        end
    end

    // State register, seeded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: scrolls three pipes left once per accepted video frame,
// one pipe per clock (STEP0..STEP2), recycling pipes that leave the screen
// with a fresh random gap, and pulsing pass_pulse when a pipe crosses the bird.
// Optional build macro PIPE_SPEEDUP_EN: adds an 8-bit saturating pass counter
// and raises the scroll speed by one px for every eight passes (max +4).
module pipe_scheduler
    import flappy_pkg::*;
#(
    parameter int unsigned SCREEN_W     = DEF_SCREEN_W,
    parameter int unsigned PIPE_W       = DEF_PIPE_W,
    parameter int unsigned PIPE_SPACING = DEF_PIPE_SPACING,
    parameter int unsigned SPEED        = DEF_SPEED,
    parameter int unsigned GAP_MIN      = DEF_GAP_MIN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        clear,
    input  logic [11:0] bird_x,
    output logic [11:0] pipe1_x,
    output logic [11:0] pipe2_x,
    output logic [11:0] pipe3_x,
    output logic [11:0] pipe1_y,
    output logic [11:0] pipe2_y,
    output logic [11:0] pipe3_y,
    output logic        pass_pulse,
    output logic        busy
);

    localparam coord_t X1_INIT   = coord_t'(SCREEN_W + PIPE_W);
    localparam coord_t X2_INIT   = coord_t'(SCREEN_W + PIPE_W + PIPE_SPACING);
    localparam coord_t X3_INIT   = coord_t'(SCREEN_W + PIPE_W + 2 * PIPE_SPACING);
    localparam coord_t Y_INIT    = coord_t'(DEF_GAP_Y_INIT);
    localparam coord_t WRAP      = coord_t'(3 * PIPE_SPACING);
    localparam coord_t SPEED_C   = coord_t'(SPEED);
    localparam coord_t GAP_MIN_C = coord_t'(GAP_MIN);

    sched_state_e state_q;
    logic         pending_q;
    logic         busy_q;
    logic         pass_q;
    pipe_t        pipe_q [NUM_PIPES];

    pipe_t        cur_d;
    pipe_t        step_d;
    logic         pass_d;
    logic         in_step;
    coord_t       fresh_y;
    coord_t       speed_eff;

    logic [15:0]  lfsr_q;
    logic         unused_lfsr_hi;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    // Only the low nine LFSR bits feed the gap position
    assign unused_lfsr_hi = ^lfsr_q[15:9];
    assign fresh_y        = GAP_MIN_C + {3'b000, lfsr_q[8:0]};

`ifdef PIPE_SPEEDUP_EN
    logic [7:0] passes_q;
    logic [2:0] bonus;

    // Saturating count of pipes passed since reset or clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            passes_q <= 8'd0;
        end else if (clear) begin
            passes_q <= 8'd0;
        end else if (in_step && pass_d && (passes_q != 8'hFF)) begin
            passes_q <= passes_q + 8'd1;
        end
    end

    // One extra px per eight passes, capped at four
    always_comb begin
        bonus     = (passes_q >= 8'd32) ? 3'd4 : {1'b0, passes_q[4:3]};
        speed_eff = SPEED_C + {9'd0, bonus};
    end
`else
    assign speed_eff = SPEED_C;
`endif

    assign in_step = (state_q == ST_STEP0) || (state_q == ST_STEP1) ||
                     (state_q == ST_STEP2);

    // Step datapath: move or recycle the pipe owned by the current STEP state
    always_comb begin
        case (state_q)
            ST_STEP1: cur_d = pipe_q[1];
            ST_STEP2: cur_d = pipe_q[2];
            default:  cur_d = pipe_q[0];
        endcase
        step_d = advance_pipe(cur_d, speed_eff, WRAP, fresh_y);
        pass_d = crosses_bird(cur_d.x, step_d.x, bird_x);
    end

    // Scheduler FSM with pipe, pending, busy and pass registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            pipe_q[0].x <= X1_INIT;
            pipe_q[1].x <= X2_INIT;
            pipe_q[2].x <= X3_INIT;
            pipe_q[0].y <= Y_INIT;
            pipe_q[1].y <= Y_INIT;
            pipe_q[2].y <= Y_INIT;
        end else if (clear) begin
            // Restart the layout from any state; the LFSR keeps running
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            pipe_q[0].x <= X1_INIT;
            pipe_q[1].x <= X2_INIT;
            pipe_q[2].x <= X3_INIT;
            pipe_q[0].y <= Y_INIT;
            pipe_q[1].y <= Y_INIT;
            pipe_q[2].y <= Y_INIT;
        end else begin
            pass_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A live tick and a stored one merge into a single update
                    if (run && (frame_tick || pending_q)) begin
                        state_q   <= ST_STEP0;
                        busy_q    <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                ST_STEP0: begin
                    pipe_q[0] <= step_d;
                    pass_q    <= pass_d;
                    state_q   <= ST_STEP1;
                    if (frame_tick) begin
                        pending_q <= 1'b1;
                    end
                end
                ST_STEP1: begin
                    pipe_q[1] <= step_d;
                    pass_q    <= pass_d;
                    state_q   <= ST_STEP2;
                    if (frame_tick) begin
                        pending_q <= 1'b1;
                    end
                end
                ST_STEP2: begin
                    pipe_q[2] <= step_d;
                    pass_q    <= pass_d;
                    state_q   <= ST_WAIT;
                    busy_q    <= 1'b0;
                    if (frame_tick) begin
                        pending_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pipe1_x    = pipe_q[0].x;
    assign pipe2_x    = pipe_q[1].x;
    assign pipe3_x    = pipe_q[2].x;
    assign pipe1_y    = pipe_q[0].y;
    assign pipe2_y    = pipe_q[1].y;
    assign pipe3_y    = pipe_q[2].y;
    assign pass_pulse = pass_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler: self-checking bench for pipe_scheduler. A frame-level
// reference model (plain integer pipe positions and a pass count) predicts
// every frame; define PIPE_SPEEDUP_EN for both RTL and bench to cover the
// speed-up build.
`timescale 1ns/1ps
module tb_pipe_scheduler;

    localparam int SCREEN_W = 1024;
    localparam int PIPE_W   = 64;
    localparam int SPACING  = 352;
    localparam int SPEED    = 4;
    localparam int GAP_MIN  = 192;
    localparam int GAP_MAX  = 192 + 511;
    localparam int Y0       = 384;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        run;
    logic        clear;
    logic [11:0] bird_x;
    logic [11:0] pipe1_x, pipe2_x, pipe3_x;
    logic [11:0] pipe1_y, pipe2_y, pipe3_y;
    logic        pass_pulse;
    logic        busy;

    logic [11:0] ox [3];
    logic [11:0] oy [3];
    assign ox[0] = pipe1_x;
    assign ox[1] = pipe2_x;
    assign ox[2] = pipe3_x;
    assign oy[0] = pipe1_y;
    assign oy[1] = pipe2_y;
    assign oy[2] = pipe3_y;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int mx [3];
    int my [3];
    int mpasses;

    pipe_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .run        (run),
        .clear      (clear),
        .bird_x     (bird_x),
        .pipe1_x    (pipe1_x),
        .pipe2_x    (pipe2_x),
        .pipe3_x    (pipe3_x),
        .pipe1_y    (pipe1_y),
        .pipe2_y    (pipe2_y),
        .pipe3_y    (pipe3_y),
        .pass_pulse (pass_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1);
    end

    function automatic int x_init(input int k);
        return SCREEN_W + PIPE_W + k * SPACING;
    endfunction

    function automatic int eff_speed();
`ifdef PIPE_SPEEDUP_EN
        return SPEED + (((mpasses / 8) > 4) ? 4 : (mpasses / 8));
`else
        return SPEED;
`endif
    endfunction

    task automatic model_init();
        for (int k = 0; k < 3; k++) begin
            mx[k] = x_init(k);
            my[k] = Y0;
        end
        mpasses = 0;
    endtask

    // One whole frame: pipes move in order 1,2,3; a pass changes speed at once
    task automatic model_frame(input int bx, output int npass, output bit [2:0] rec);
        npass = 0;
        rec   = 3'b000;
        for (int k = 0; k < 3; k++) begin
            int s;
            int nx;
            s = eff_speed();
            if (mx[k] <= s) begin
                nx     = mx[k] - s + 3 * SPACING;
                rec[k] = 1'b1;
            end else begin
                nx = mx[k] - s;
            end
            if (mx[k] > bx && nx <= bx) begin
                npass++;
                if (mpasses < 255) mpasses++;
            end
            mx[k] = nx;
        end
    endtask

    // Issue one tick and follow the update; returns pass pulses and busy cycles
    task automatic run_frame(output int npulse, output int nbusy);
        npulse = 0;
        nbusy  = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (pass_pulse === 1'b1) npulse++;
            if (busy === 1'b1) nbusy++;
            else break;
            @(negedge clk);
        end
    endtask

    task automatic restart();
        @(negedge clk);
        clear      = 1'b1;
        frame_tick = 1'b0;
        run        = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        run   = 1'b1;
        @(negedge clk);
        model_init();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; frame_tick = 1'b0; clear = 1'b0; bird_x = 12'd0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ox[k] !== 12'(x_init(k))) begin
                n_bad++; $display("FAIL reset_x%0d got %0d want %0d", k + 1, ox[k], x_init(k));
            end
            n_cmp++;
            if (oy[k] !== 12'(Y0)) begin
                n_bad++; $display("FAIL reset_y%0d got %0d want %0d", k + 1, oy[k], Y0);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || pass_pulse !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags got busy=%b pass=%b want 0/0", busy, pass_pulse);
        end
        rst_n = 1'b1;
        run   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (pass_pulse !== 1'b0 || busy !== 1'b0 || pipe1_x !== 12'd1088) begin
                n_bad++;
                $display("FAIL reset_release got pass=%b busy=%b x1=%0d want 0/0/1088",
                         pass_pulse, busy, pipe1_x);
            end
        end
        // Asynchronous reset in the middle of a frame
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pipe1_x !== 12'd1084) begin
            n_bad++; $display("FAIL pre_async_x1 got %0d want 1084", pipe1_x);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pipe1_x !== 12'd1088 || busy !== 1'b0) begin
            n_bad++; $display("FAIL async_reset got x1=%0d busy=%b want 1088/0", pipe1_x, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b0;
    endtask

    task automatic test_first_frame();
        int nb;
        restart();
        bird_x = 12'd0;
        nb = 0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        if (busy === 1'b1) nb++;
        n_cmp++;
        if (busy !== 1'b1 || pipe1_x !== 12'd1088) begin
            n_bad++; $display("FAIL step0 got busy=%b x1=%0d want 1/1088", busy, pipe1_x);
        end
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
            for (int k = 0; k < 3; k++) begin
                int want;
                want = (k < e) ? x_init(k) - SPEED : x_init(k);
                n_cmp++;
                if (ox[k] !== 12'(want)) begin
                    n_bad++; $display("FAIL edge%0d_x%0d got %0d want %0d", e, k + 1, ox[k], want);
                end
            end
            n_cmp++;
            if (busy !== (e < 3) || pass_pulse !== 1'b0) begin
                n_bad++; $display("FAIL edge%0d_flags got busy=%b pass=%b want %0d/0",
                                  e, busy, pass_pulse, (e < 3));
            end
        end
        n_cmp++;
        if (nb != 3) begin
            n_bad++; $display("FAIL busy_cycles got %0d want 3", nb);
        end
    endtask

    task automatic test_pass_recycle();
        int np, nb, ep;
        bit [2:0] rec;
        restart();
        bird_x = 12'd200;
        for (int t = 1; t <= 272; t++) begin
            model_frame(200, ep, rec);
            run_frame(np, nb);
            n_cmp++;
            if (np != ep || nb != 3) begin
                n_bad++; $display("FAIL frame%0d_pass got pass=%0d busy=%0d want %0d/3", t, np, nb, ep);
            end
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (ox[k] !== 12'(mx[k])) begin
                    n_bad++; $display("FAIL frame%0d_x%0d got %0d want %0d", t, k + 1, ox[k], mx[k]);
                end
                n_cmp++;
                if (rec[k]) begin
                    if ($isunknown(oy[k]) || oy[k] < 12'(GAP_MIN) || oy[k] > 12'(GAP_MAX)) begin
                        n_bad++; $display("FAIL frame%0d_y%0d got %0d want 192..703", t, k + 1, oy[k]);
                    end
                    my[k] = int'(oy[k]);
                end else if (oy[k] !== 12'(my[k])) begin
                    n_bad++; $display("FAIL frame%0d_y%0d got %0d want %0d", t, k + 1, oy[k], my[k]);
                end
            end
            if (t == 222) begin
                n_cmp++;
                if (pipe1_x !== 12'd200 || np != 1) begin
                    n_bad++; $display("FAIL tick222 got x1=%0d pass=%0d want 200/1", pipe1_x, np);
                end
            end
            if (t == 223) begin
                n_cmp++;
                if (np != 0) begin
                    n_bad++; $display("FAIL tick223 got pass=%0d want 0", np);
                end
            end
            if (t == 271) begin
                n_cmp++;
                if (pipe1_x !== 12'd4) begin
                    n_bad++; $display("FAIL tick271 got x1=%0d want 4", pipe1_x);
                end
            end
            if (t == 272) begin
                n_cmp++;
                if (pipe1_x !== 12'd1056 || $isunknown(pipe1_y) ||
                    pipe1_y < 12'd192 || pipe1_y > 12'd703) begin
                    n_bad++; $display("FAIL tick272 got x1=%0d y1=%0d want 1056/192..703",
                                      pipe1_x, pipe1_y);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        int np;
        restart();
        bird_x = 12'd0;
        nb = 0;
        np = 0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        if (busy === 1'b1) nb++;
        @(negedge clk); frame_tick = 1'b1;
        if (busy === 1'b1) nb++;
        @(negedge clk); frame_tick = 1'b1;
        if (busy === 1'b1) nb++;
        @(negedge clk); frame_tick = 1'b0;
        if (busy === 1'b1) nb++;
        n_cmp++;
        if (pipe1_x !== 12'd1084 || pipe3_x !== 12'd1788) begin
            n_bad++; $display("FAIL b2b_first got x1=%0d x3=%0d want 1084/1788", pipe1_x, pipe3_x);
        end
        repeat (12) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
            if (pass_pulse === 1'b1) np++;
        end
        n_cmp++;
        if (nb != 6 || np != 0) begin
            n_bad++; $display("FAIL b2b_busy got busy_cycles=%0d pass=%0d want 6/0", nb, np);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ox[k] !== 12'(x_init(k) - 2 * SPEED)) begin
                n_bad++; $display("FAIL b2b_x%0d got %0d want %0d", k + 1, ox[k], x_init(k) - 2 * SPEED);
            end
        end
    endtask

    task automatic test_clear();
        restart();
        bird_x = 12'd0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b1;
        n_cmp++;
        if (pipe1_x !== 12'd1084) begin
            n_bad++; $display("FAIL clear_pre got x1=%0d want 1084", pipe1_x);
        end
        clear = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        frame_tick = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ox[k] !== 12'(x_init(k)) || oy[k] !== 12'(Y0)) begin
                n_bad++; $display("FAIL clear_pipe%0d got x=%0d y=%0d want %0d/%0d",
                                  k + 1, ox[k], oy[k], x_init(k), Y0);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || pass_pulse !== 1'b0) begin
            n_bad++; $display("FAIL clear_flags got busy=%b pass=%b want 0/0", busy, pass_pulse);
        end
        repeat (6) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || pipe1_x !== 12'd1088) begin
                n_bad++; $display("FAIL clear_pending got busy=%b x1=%0d want 0/1088", busy, pipe1_x);
            end
        end
        run = 1'b0;
        repeat (3) begin
            @(negedge clk); frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0;
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++; $display("FAIL frozen_busy got %b want 0", busy);
            end
        end
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ox[k] !== 12'(x_init(k))) begin
                n_bad++; $display("FAIL frozen_x%0d got %0d want %0d", k + 1, ox[k], x_init(k));
            end
        end
    endtask

    task automatic test_random();
        int np, nb, ep;
        bit [2:0] rec;
        restart();
        for (int t = 1; t <= 300; t++) begin
            bird_x = 12'($urandom_range(0, 1199));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            model_frame(int'(bird_x), ep, rec);
            run_frame(np, nb);
            n_cmp++;
            if (np != ep || nb != 3) begin
                n_bad++; $display("FAIL rnd%0d_pass got pass=%0d busy=%0d want %0d/3 (bird %0d)",
                                  t, np, nb, ep, bird_x);
            end
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (ox[k] !== 12'(mx[k])) begin
                    n_bad++; $display("FAIL rnd%0d_x%0d got %0d want %0d", t, k + 1, ox[k], mx[k]);
                end
                if (rec[k]) begin
                    n_cmp++;
                    if ($isunknown(oy[k]) || oy[k] < 12'(GAP_MIN) || oy[k] > 12'(GAP_MAX)) begin
                        n_bad++; $display("FAIL rnd%0d_y%0d got %0d want 192..703", t, k + 1, oy[k]);
                    end
                    my[k] = int'(oy[k]);
                end else begin
                    n_cmp++;
                    if (oy[k] !== 12'(my[k])) begin
                        n_bad++; $display("FAIL rnd%0d_y%0d got %0d want %0d", t, k + 1, oy[k], my[k]);
                    end
                end
            end
        end
    endtask

`ifdef PIPE_SPEEDUP_EN
    task automatic test_speedup();
        int np, nb, ep;
        int before [3];
        bit [2:0] rec;
        restart();
        for (int t = 1; t <= 8; t++) begin
            bird_x = 12'(mx[0] - eff_speed());
            model_frame(int'(bird_x), ep, rec);
            run_frame(np, nb);
            n_cmp++;
            if (np != ep || ox[0] !== 12'(mx[0]) || ox[2] !== 12'(mx[2])) begin
                n_bad++; $display("FAIL speed_pass%0d got pass=%0d x1=%0d x3=%0d want %0d/%0d/%0d",
                                  t, np, ox[0], ox[2], ep, mx[0], mx[2]);
            end
        end
        bird_x = 12'd0;
        for (int k = 0; k < 3; k++) before[k] = int'(ox[k]);
        model_frame(0, ep, rec);
        run_frame(np, nb);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (before[k] - int'(ox[k]) != 5 || ox[k] !== 12'(mx[k])) begin
                n_bad++; $display("FAIL speed_step_x%0d got %0d want %0d (5 px)", k + 1, ox[k], before[k] - 5);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_frame();
        test_pass_recycle();
        test_back_to_back();
        test_clear();
        test_random();
`ifdef PIPE_SPEEDUP_EN
        test_speedup();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
